// File: rtl/avmm_reg_bank.sv
// avmm_reg_bank
//   Avalon-MM slave register bank. NUM_REGS registers of DATA_W bits each.
//   Each register is one of three kinds, chosen per index by the masks:
//     RW  : byte-enabled writes, reset to its RESET_VAL slice.
//     RO  : no storage, mirrors the status_in slice.
//     W1C : sticky status. Hardware sets bits via status_in and software
//           clears them by writing 1s. A set wins over a clear on the same bit.
//   Reads are registered with a fixed latency of 1 and a readdatavalid pulse.
//   There is no waitrequest.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   address             word address (ADDR_W)
//   write_n, read_n     active-low strobes; both may be low in the same cycle
//   writedata           write data (DATA_W)
//   byteenable          write byte lanes (DATA_W/8)
//   readdata            registered read data; holds its value between reads
//   readdatavalid       one-cycle pulse for each read
//   status_in           hardware status, slice i = [i*DATA_W +: DATA_W]
//   reg_data            current value of every register, same slicing
//   irq                 registered OR of every W1C register bit
module avmm_reg_bank #(
  parameter int                         NUM_REGS  = 8,
  parameter int                         DATA_W    = 32,
  parameter int                         ADDR_W    = 3,
  parameter logic [63:0]                RO_MASK   = '0,
  parameter logic [63:0]                W1C_MASK  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         write_n,
  input  logic                         read_n,
  input  logic [DATA_W-1:0]            writedata,
  input  logic [DATA_W/8-1:0]          byteenable,
  output logic [DATA_W-1:0]            readdata,
  output logic                         readdatavalid,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_data,
  output logic                         irq
);

  localparam int BE_W = DATA_W / 8;

  // Expand one bit per byte lane into a full-width bit mask.
  function automatic logic [DATA_W-1:0] be_expand(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < BE_W; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_mask;

  assign wr_en   = !write_n;
  assign rd_en   = !read_n;
  assign wr_mask = be_expand(byteenable);

  // Next-cycle OR of each W1C register, so that irq tracks the post-update value.
  logic [NUM_REGS-1:0] w1c_any_d;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_data[i*DATA_W +: DATA_W] = status_in[i*DATA_W +: DATA_W];
      assign w1c_any_d[i] = 1'b0;
    end else begin : g_st
      localparam logic [DATA_W-1:0] RST_VAL =
        W1C_MASK[i] ? '0 : RESET_VAL[i*DATA_W +: DATA_W];

      logic              wr_sel;
      logic [DATA_W-1:0] val_d;
      logic [DATA_W-1:0] val_q;

      assign wr_sel = wr_en && (address == ADDR_W'(i));

      always_comb begin
        val_d = val_q;
        if (W1C_MASK[i]) begin
          // Clear first, then OR in status so that a set wins per bit.
          val_d = (val_q & ~(wr_sel ? (writedata & wr_mask) : '0))
                | status_in[i*DATA_W +: DATA_W];
        end else if (wr_sel) begin
          val_d = (val_q & ~wr_mask) | (writedata & wr_mask);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          val_q <= RST_VAL;
        end else begin
          val_q <= val_d;
        end
      end

      assign reg_data[i*DATA_W +: DATA_W] = val_q;
      assign w1c_any_d[i] = W1C_MASK[i] ? (|val_d) : 1'b0;
    end
  end

  // RW slices never look at status_in.
  logic unused_status;
  assign unused_status = ^status_in;

  // Read mux over the current (pre-write) values. Out-of-range addresses give 0.
  logic [DATA_W-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (address == ADDR_W'(k)) begin
        rd_val = reg_data[k*DATA_W +: DATA_W];
      end
    end
  end

  logic [DATA_W-1:0] readdata_d, readdata_q;
  logic              readdatavalid_d, readdatavalid_q;
  logic              irq_d, irq_q;

  always_comb begin
    readdata_d      = rd_en ? rd_val : readdata_q;
    readdatavalid_d = rd_en;
    irq_d           = |w1c_any_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      irq_q           <= irq_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_avmm_reg_bank.sv
// Directed bench for avmm_reg_bank.
// Bank map: 6 registers, reg 2 RW with reset value 0xFF, reg 3 W1C, reg 4 RO,
// the remaining registers RW resetting to 0. Addresses 6 and 7 are unmapped.
module tb_avmm_reg_bank;

  localparam int NUM    = 6;
  localparam int DW     = 32;
  localparam int AW     = 3;
  localparam logic [NUM*DW-1:0] RV =
    {32'h0, 32'h0, 32'h0, 32'h0000_00FF, 32'h0, 32'h0};

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [AW-1:0]   address = '0;
  logic            write_n = 1'b1;
  logic            read_n = 1'b1;
  logic [DW-1:0]   writedata = '0;
  logic [DW/8-1:0] byteenable = '0;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic [NUM*DW-1:0] status_in = '0;
  logic [NUM*DW-1:0] reg_data;
  logic            irq;

  avmm_reg_bank #(
    .NUM_REGS (NUM),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .RO_MASK  (64'h10),
    .W1C_MASK (64'h08),
    .RESET_VAL(RV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .write_n      (write_n),
    .read_n       (read_n),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .status_in    (status_in),
    .reg_data     (reg_data),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_n = 1'b1;
    read_n  = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write_n = 1'b0;
    cyc();
    idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic v);
    address = a; read_n = 1'b0;
    cyc();
    d = readdata;
    v = readdatavalid;
    idle();
  endtask

  function automatic logic [31:0] slice(input int i);
    return reg_data[i*DW +: DW];
  endfunction

  logic [31:0] rd;
  logic        rv;
  logic [31:0] exp_img [NUM];

  initial begin
    status_in[4*DW +: DW] = 32'h1234_5678;
    cyc(); cyc();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_rdvalid", {31'h0, readdatavalid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_slice2", slice(2), 32'h0000_00FF);
    chk("rst_slice3_w1c", slice(3), 32'h0);
    chk("rst_slice4_ro", slice(4), 32'h1234_5678);
    reset_n = 1'b1;
    cyc();

    // Reset values and read latency.
    do_read(3'd2, rd, rv);
    chk("rd2_data", rd, 32'h0000_00FF);
    chk("rd2_valid", {31'h0, rv}, 32'h1);
    cyc();
    chk("rd2_valid_drop", {31'h0, readdatavalid}, 32'h0);
    chk("rd2_hold", readdata, 32'h0000_00FF);
    foreach (exp_img[i]) exp_img[i] = 32'h0;
    do_read(3'd0, rd, rv); chk("rd0_rst", rd, 32'h0);
    do_read(3'd1, rd, rv); chk("rd1_rst", rd, 32'h0);
    do_read(3'd5, rd, rv); chk("rd5_rst", rd, 32'h0);

    // Byte-enabled write.
    do_write(3'd1, 32'hDEAD_BEEF, 4'b0101);
    chk("wr1_slice", slice(1), 32'h00AD_00EF);
    do_read(3'd1, rd, rv);
    chk("wr1_read", rd, 32'h00AD_00EF);

    // W1C set by a one-cycle status pulse, cleared by writes.
    status_in[3*DW +: DW] = 32'h8000_0001;
    cyc();
    status_in[3*DW +: DW] = 32'h0;
    chk("w1c_set", slice(3), 32'h8000_0001);
    chk("w1c_irq_set", {31'h0, irq}, 32'h1);
    cyc();
    chk("w1c_sticky", slice(3), 32'h8000_0001);
    do_write(3'd3, 32'h0000_0001, 4'hF);
    chk("w1c_clr0", slice(3), 32'h8000_0000);
    chk("w1c_irq_hold", {31'h0, irq}, 32'h1);
    do_write(3'd3, 32'h8000_0000, 4'hF);
    chk("w1c_clr31", slice(3), 32'h0);
    chk("w1c_irq_clr", {31'h0, irq}, 32'h0);

    // Set and clear of the same bit in one cycle: set wins.
    status_in[3*DW +: DW] = 32'h0000_0001;
    do_write(3'd3, 32'h0000_0001, 4'hF);
    status_in[3*DW +: DW] = 32'h0;
    chk("w1c_set_wins", slice(3), 32'h0000_0001);
    chk("w1c_set_wins_irq", {31'h0, irq}, 32'h1);
    // Clear with byte lane 0 disabled has no effect.
    do_write(3'd3, 32'h0000_0001, 4'b1110);
    chk("w1c_be_masked", slice(3), 32'h0000_0001);
    do_write(3'd3, 32'h0000_0001, 4'b0001);
    chk("w1c_final_clr", slice(3), 32'h0);

    // RO register ignores writes.
    do_write(3'd4, 32'hFFFF_FFFF, 4'hF);
    do_read(3'd4, rd, rv);
    chk("ro_read", rd, 32'h1234_5678);

    // Unmapped addresses.
    do_read(3'd7, rd, rv);
    chk("rd7_data", rd, 32'h0);
    chk("rd7_valid", {31'h0, rv}, 32'h1);
    do_write(3'd7, 32'hFFFF_FFFF, 4'hF);
    do_write(3'd6, 32'hFFFF_FFFF, 4'hF);
    exp_img[1] = 32'h00AD_00EF;
    exp_img[2] = 32'h0000_00FF;
    exp_img[4] = 32'h1234_5678;
    for (int i = 0; i < NUM; i++) chk($sformatf("unmapped_wr_slice%0d", i), slice(i), exp_img[i]);

    // Simultaneous read and write return the old value.
    do_write(3'd0, 32'h0000_0011, 4'hF);
    address = 3'd0; writedata = 32'h0000_0022; byteenable = 4'hF;
    write_n = 1'b0; read_n = 1'b0;
    cyc();
    idle();
    chk("rw_same_old", readdata, 32'h0000_0011);
    chk("rw_same_slice", slice(0), 32'h0000_0022);
    do_read(3'd0, rd, rv);
    chk("rw_same_new", rd, 32'h0000_0022);

    // Reset while a read is in flight.
    address = 3'd2; read_n = 1'b0;
    cyc();
    chk("pre_rst_valid", {31'h0, readdatavalid}, 32'h1);
    chk("pre_rst_data", readdata, 32'h0000_00FF);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, readdatavalid}, 32'h0);
    chk("mid_rst_data", readdata, 32'h0);
    chk("mid_rst_slice0", slice(0), 32'h0);
    chk("mid_rst_slice1", slice(1), 32'h0);
    idle();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_valid", {31'h0, readdatavalid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
